// File: rtl/vertical_draw.sv
// Vertical timing stage fed by horizontal_draw line_end pulses.
// Decodes region from line count against per-frame shadow config.
module vertical_draw #(
  parameter int WIDTH = 12,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             line_end,
  input  logic             h_output_flag,
  input  logic [WIDTH-1:0] v_back_porch,
  input  logic [WIDTH-1:0] v_active_lines,
  input  logic [WIDTH-1:0] v_front_porch,
  input  logic [WIDTH-1:0] v_sync_length,
  input  logic [WIDTH-1:0] v_total_lines,
  output logic [WIDTH-1:0] line_count,
  output logic             v_active_flag,
  output logic             v_sync,
  output logic             frame_start,
  output logic             pixel_enable
);

  typedef enum logic [1:0] {
    VBP,
    VACTIVE,
    VFP,
    VSLEN
  } state_t;

  localparam int BW = WIDTH + 2;

  state_t           state;
  state_t           nxt_state;
  logic [WIDTH-1:0] nxt_line;
  logic [WIDTH-1:0] bp_q;
  logic [WIDTH-1:0] act_q;
  logic [WIDTH-1:0] fp_q;
  logic [WIDTH-1:0] tot_q;
  logic [WIDTH:0]   inc;
  logic             advance;
  logic             wrap;

  // Sync length is implied: sync fills whatever the other regions leave.
  logic unused_sync;
  assign unused_sync = ^v_sync_length;

  function automatic state_t decode(
    logic [WIDTH-1:0] line,
    logic [WIDTH-1:0] bp,
    logic [WIDTH-1:0] act,
    logic [WIDTH-1:0] fp
  );
    logic [BW-1:0] b1, b2, b3, l;
    b1 = BW'(bp);
    b2 = b1 + BW'(act);
    b3 = b2 + BW'(fp);
    l  = BW'(line);
    if (l < b1)      decode = VBP;
    else if (l < b2) decode = VACTIVE;
    else if (l < b3) decode = VFP;
    else             decode = VSLEN;
  endfunction

  assign advance = enable & line_end;
  assign inc     = {1'b0, line_count} + 1'b1;
  // Totals of 0 or 1 wrap on every line.
  assign wrap    = inc >= {1'b0, tot_q};

  // Next line and region; wrap decodes against the freshly loaded config.
  always_comb begin
    nxt_line  = line_count;
    nxt_state = state;
    if (advance) begin
      if (wrap) begin
        nxt_line  = '0;
        nxt_state = decode('0, v_back_porch,
                           v_active_lines, v_front_porch);
      end else begin
        nxt_line  = inc[WIDTH-1:0];
        nxt_state = decode(inc[WIDTH-1:0], bp_q, act_q, fp_q);
      end
    end else if (enable) begin
      nxt_state = decode(line_count, bp_q, act_q, fp_q);
    end
  end

  // Line counter, region, shadow config and registered outputs.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      line_count    <= '0;
      state         <= decode('0, v_back_porch,
                              v_active_lines, v_front_porch);
      bp_q          <= v_back_porch;
      act_q         <= v_active_lines;
      fp_q          <= v_front_porch;
      tot_q         <= v_total_lines;
      v_active_flag <= 1'b0;
      v_sync        <= ~VSYNC_ACTIVE_HIGH;
      frame_start   <= 1'b0;
      pixel_enable  <= 1'b0;
    end else begin
      frame_start   <= advance & wrap;
      pixel_enable  <= v_active_flag & h_output_flag & enable;
      line_count    <= nxt_line;
      state         <= nxt_state;
      v_active_flag <= nxt_state == VACTIVE;
      v_sync        <= (nxt_state == VSLEN) ?
                       VSYNC_ACTIVE_HIGH : ~VSYNC_ACTIVE_HIGH;
      if (advance & wrap) begin
        bp_q  <= v_back_porch;
        act_q <= v_active_lines;
        fp_q  <= v_front_porch;
        tot_q <= v_total_lines;
      end
    end
  end

endmodule

// File: tb/tb_vertical_draw.sv
// Directed bench for vertical_draw with a reference line model
// and a scoreboard queue of expected per-line outputs.
module tb_vertical_draw;

  localparam int W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         line_end = 1'b0;
  logic         h = 1'b0;
  logic [W-1:0] bp = 2, act = 4, fp = 1, sl = 2, tot = 9;

  logic [W-1:0] lc, lc_n;
  logic         vaf, vs, fs, pe;
  logic         vaf_n, vs_n, fs_n, pe_n;

  vertical_draw #(.WIDTH(W), .VSYNC_ACTIVE_HIGH(1'b1)) dut (
    .clock_50(clk), .reset(reset), .enable(enable),
    .line_end(line_end), .h_output_flag(h),
    .v_back_porch(bp), .v_active_lines(act),
    .v_front_porch(fp), .v_sync_length(sl),
    .v_total_lines(tot), .line_count(lc),
    .v_active_flag(vaf), .v_sync(vs),
    .frame_start(fs), .pixel_enable(pe)
  );

  vertical_draw #(.WIDTH(W), .VSYNC_ACTIVE_HIGH(1'b0)) dut_n (
    .clock_50(clk), .reset(reset), .enable(enable),
    .line_end(line_end), .h_output_flag(h),
    .v_back_porch(bp), .v_active_lines(act),
    .v_front_porch(fp), .v_sync_length(sl),
    .v_total_lines(tot), .line_count(lc_n),
    .v_active_flag(vaf_n), .v_sync(vs_n),
    .frame_start(fs_n), .pixel_enable(pe_n)
  );

  typedef struct packed {
    logic [W-1:0] lc;
    logic         vaf;
    logic         vs;
    logic         fs;
  } exp_t;

  exp_t q[$];
  logic pq[$];
  int total = 0;
  int bad = 0;
  int m_lc, m_bp, m_act, m_fp, m_tot;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_model();
    m_bp  = int'(bp);
    m_act = int'(act);
    m_fp  = int'(fp);
    m_tot = int'(tot);
  endtask

  function automatic exp_t model_out(logic f);
    exp_t e;
    e.lc  = W'(m_lc);
    e.vaf = (m_lc >= m_bp) && (m_lc < m_bp + m_act);
    e.vs  = m_lc >= m_bp + m_act + m_fp;
    e.fs  = f;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    line_end = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("rst_lc", 32'(lc), 0);
    chk("rst_vaf", 32'(vaf), 0);
    chk("rst_vs", 32'(vs), 0);
    chk("rst_fs", 32'(fs), 0);
    chk("rst_pe", 32'(pe), 0);
    chk("rst_vs_n", 32'(vs_n), 1);
    reset = 1'b0;
    m_lc = 0;
    load_model();
    q.delete();
    @(negedge clk);
  endtask

  task automatic pulse(input logic en);
    exp_t e;
    logic f;
    @(negedge clk);
    enable = en;
    line_end = 1'b1;
    f = 1'b0;
    if (en) begin
      if (m_lc + 1 >= m_tot) begin
        m_lc = 0;
        f = 1'b1;
        load_model();
      end else begin
        m_lc++;
      end
    end
    q.push_back(model_out(f));
    @(negedge clk);
    line_end = 1'b0;
    e = q.pop_front();
    chk("lc", 32'(lc), 32'(e.lc));
    chk("vaf", 32'(vaf), 32'(e.vaf));
    chk("vs", 32'(vs), 32'(e.vs));
    chk("fs", 32'(fs), 32'(e.fs));
    if (!en) chk("pe_off", 32'(pe), 0);
    enable = 1'b1;
  endtask

  initial begin
    // Base frame: bp=2 act=4 fp=1 total=9.
    do_reset();
    h = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pe_vbp", 32'(pe), 0);
    h = 1'b0;
    for (int i = 0; i < 3; i++) pulse(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      h = i[0];
      pq.push_back(i[0]);
      @(negedge clk);
      chk("pe_act", 32'(pe), 32'(pq.pop_front()));
    end
    h = 1'b0;
    for (int i = 0; i < 17; i++) pulse(1'b1);
    chk("end_lc", 32'(lc), 2);

    // Active length change mid-frame lands at the next frame.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1);
    act = 2;
    for (int i = 0; i < 15; i++) pulse(1'b1);
    act = 4;

    // Freeze while enable is low.
    do_reset();
    for (int i = 0; i < 4; i++) pulse(1'b1);
    h = 1'b1;
    for (int i = 0; i < 5; i++) pulse(1'b0);
    h = 1'b0;
    pulse(1'b1);
    chk("resume_lc", 32'(lc), 5);

    // Reset coinciding with line_end at line 7.
    pulse(1'b1);
    pulse(1'b1);
    chk("pre_rst_lc", 32'(lc), 7);
    @(negedge clk);
    reset = 1'b1;
    line_end = 1'b1;
    @(negedge clk);
    chk("rl_lc", 32'(lc), 0);
    chk("rl_vs", 32'(vs), 0);
    chk("rl_fs", 32'(fs), 0);
    chk("rl_vs_n", 32'(vs_n), 1);
    reset = 1'b0;
    line_end = 1'b0;

    // Empty porches: active from line 0, sync on 4..5.
    bp = 0;
    fp = 0;
    tot = 6;
    do_reset();
    @(negedge clk);
    chk("bp0_vaf", 32'(vaf), 1);
    chk("bp0_lc", 32'(lc), 0);
    for (int i = 0; i < 8; i++) pulse(1'b1);

    // Degenerate totals.
    tot = 1;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1);
    tot = 0;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
